// File: rtl/fetch_ctrl.sv
// Instruction-fetch control FSM: sequences PC load, memory read, IR capture
// and redirect selection, with a saturating memory-timeout watchdog.
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH      = 4
) (
  input  logic       fetch_ctrl_clock_in,
  input  logic       fetch_ctrl_reset_in,
  input  logic       fetch_enable_in,
  input  logic       mem_ready_in,
  input  logic       stall_in,
  input  logic       jump_in,
  input  logic       branch_taken_in,
  output logic       mem_req_out,
  output logic       pc_set_out,
  output logic [1:0] pc_mux_sel_out,
  output logic       ir_set_out,
  output logic       ir_valid_out,
  output logic       fetch_error_out,
  output logic [2:0] fetch_state_out
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'b000,
    S_IDLE   = 3'b001,
    S_FETCH  = 3'b010,
    S_UPDATE = 3'b011,
    S_ERROR  = 3'b100
  } state_e;

  localparam logic [1:0] SEL_ABS  = 2'b00;
  localparam logic [1:0] SEL_REL  = 2'b01;
  localparam logic [1:0] SEL_SEQ  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic       mem_req_c, pc_set_c, ir_set_c, ir_valid_c, err_c;
  logic [1:0] sel_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    mem_req_c  = 1'b0;
    pc_set_c   = 1'b0;
    sel_c      = 2'b00;
    ir_set_c   = 1'b0;
    ir_valid_c = 1'b0;
    err_c      = 1'b0;
    case (state_q)
      S_BOOT: begin
        pc_set_c = 1'b1;
        sel_c    = SEL_ZERO;
        state_d  = S_FETCH;
      end
      S_IDLE: begin
        if (fetch_enable_in) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready_in) begin
          ir_set_c = 1'b1;
          cnt_d    = '0;
          state_d  = S_UPDATE;
        end else if (cnt_q >= CNT_LAST) begin
          // This cycle is the TIMEOUT_CYCLES-th unanswered request.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        ir_valid_c = 1'b1;
        if (!stall_in) begin
          pc_set_c = 1'b1;
          if (jump_in)              sel_c = SEL_ABS;
          else if (branch_taken_in) sel_c = SEL_REL;
          else                      sel_c = SEL_SEQ;
          state_d = fetch_enable_in ? S_FETCH : S_IDLE;
        end
      end
      S_ERROR: begin
        err_c = err_q;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge fetch_ctrl_clock_in) begin
    if (!fetch_ctrl_reset_in) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset overrides every output so an in-flight access cannot pulse anything.
  assign mem_req_out     = fetch_ctrl_reset_in & mem_req_c;
  assign pc_set_out      = fetch_ctrl_reset_in & pc_set_c;
  assign pc_mux_sel_out  = fetch_ctrl_reset_in ? sel_c : 2'b00;
  assign ir_set_out      = fetch_ctrl_reset_in & ir_set_c;
  assign ir_valid_out    = fetch_ctrl_reset_in & ir_valid_c;
  assign fetch_error_out = fetch_ctrl_reset_in & err_c;
  assign fetch_state_out = fetch_ctrl_reset_in ? state_q : 3'b000;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: per-cycle stimulus and expected output
// vectors are queued together, then applied and compared cycle by cycle.
module tb_fetch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en, rdy, stall, jmp, br;
  logic       mem_req, pc_set, ir_set, ir_valid, ferr;
  logic [1:0] sel;
  logic [2:0] st;

  int n_vec = 0;
  int n_err = 0;

  // stimulus: {rst_n, en, rdy, stall, jmp, br}
  logic [5:0] stim_q[$];
  // expected: {mem_req, pc_set, sel[1:0], ir_set, ir_valid, err, state[2:0]}
  logic [9:0] exp_q[$];
  logic [9:0] exp_v, obs_v;

  localparam logic [2:0] BOOT = 3'd0, IDLE = 3'd1, FETCH = 3'd2, UPD = 3'd3, ERR = 3'd4;

  fetch_ctrl #(.TIMEOUT_CYCLES(15), .CNT_WIDTH(4)) dut (
    .fetch_ctrl_clock_in (clk),
    .fetch_ctrl_reset_in (rst_n),
    .fetch_enable_in     (en),
    .mem_ready_in        (rdy),
    .stall_in            (stall),
    .jump_in             (jmp),
    .branch_taken_in     (br),
    .mem_req_out         (mem_req),
    .pc_set_out          (pc_set),
    .pc_mux_sel_out      (sel),
    .ir_set_out          (ir_set),
    .ir_valid_out        (ir_valid),
    .fetch_error_out     (ferr),
    .fetch_state_out     (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builders, one per architectural situation.
  function automatic logic [9:0] v_zero();
    return 10'b0;
  endfunction
  function automatic logic [9:0] v_boot();
    return {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, BOOT};
  endfunction
  function automatic logic [9:0] v_fetch(input logic ready);
    return {1'b1, 1'b0, 2'b00, ready, 1'b0, 1'b0, FETCH};
  endfunction
  function automatic logic [9:0] v_upd(input logic set, input logic [1:0] s);
    return {1'b0, set, s, 1'b0, 1'b1, 1'b0, UPD};
  endfunction
  function automatic logic [9:0] v_idle();
    return {7'b0, IDLE};
  endfunction
  function automatic logic [9:0] v_err();
    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, ERR};
  endfunction

  function automatic logic [5:0] rnd_rest(input logic r);
    logic [4:0] x;
    x = 5'($urandom_range(0, 31));
    return {r, x};
  endfunction

  task automatic push(input logic [5:0] s, input logic [9:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [5:0] s);
    @(negedge clk);
    {rst_n, en, rdy, stall, jmp, br} = s;
    #1;
    obs_v = {mem_req, pc_set, sel, ir_set, ir_valid, ferr, st};
  endtask

  task automatic test_reset();
    push(rnd_rest(1'b0), v_zero());
    push(rnd_rest(1'b0), v_zero());
    push(6'b1_1_1_0_0_0, v_boot());
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      push(6'b1_1_1_0_0_0, v_fetch(1'b1));
      push(6'b1_1_1_0_0_0, v_upd(1'b1, 2'b10));
    end
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL stream step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 3; k++) push(6'b1_1_0_0_0_0, v_fetch(1'b0));
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    push(6'b1_1_0_0_0_1, v_upd(1'b1, 2'b01));
    // 14 unanswered cycles is one short of the timeout
    for (int k = 0; k < 14; k++) push(6'b1_1_0_0_0_0, v_fetch(1'b0));
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    push(6'b1_1_0_0_0_0, v_upd(1'b1, 2'b10));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL wait_states step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_redirect();
    push(6'b1_1_1_0_1_1, v_fetch(1'b1));
    push(6'b1_1_0_0_1_1, v_upd(1'b1, 2'b00));
    push(6'b1_1_1_0_0_1, v_fetch(1'b1));
    push(6'b1_1_0_0_0_1, v_upd(1'b1, 2'b01));
    push(6'b1_1_1_0_1_0, v_fetch(1'b1));
    push(6'b1_1_0_0_1_0, v_upd(1'b1, 2'b00));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL redirect step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    push(6'b1_1_0_1_1_0, v_upd(1'b0, 2'b00));
    push(6'b1_1_0_1_1_1, v_upd(1'b0, 2'b00));
    push(6'b1_1_0_0_1_0, v_upd(1'b1, 2'b00));
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL stall step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_idle_and_reset();
    push(6'b1_0_0_0_0_0, v_upd(1'b1, 2'b10));
    push(6'b1_0_1_0_1_1, v_idle());
    push(6'b1_0_1_1_1_0, v_idle());
    push(6'b1_1_0_0_0_0, v_idle());
    push(6'b1_1_0_0_0_0, v_fetch(1'b0));
    push({1'b0, 5'b1_1_0_1_1}, v_zero());
    push(rnd_rest(1'b0), v_zero());
    push(6'b1_1_0_0_0_0, v_boot());
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    push({1'b0, 5'b1_0_0_1_0}, v_zero());
    push(6'b1_1_0_0_0_0, v_boot());
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL idle_reset step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 15; k++) push(6'b1_1_0_0_0_0, v_fetch(1'b0));
    for (int k = 0; k < 5; k++) push(rnd_rest(1'b1), v_err());
    push(rnd_rest(1'b0), v_zero());
    push(6'b1_1_1_0_0_0, v_boot());
    push(6'b1_1_1_0_0_0, v_fetch(1'b1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL timeout step %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    {rst_n, en, rdy, stall, jmp, br} = 6'b0;
    test_reset();
    test_stream();
    test_wait_states();
    test_redirect();
    test_stall();
    test_idle_and_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
